addsub_serial16: RTL and testbench

Nibble-serial 16-bit signed adder/subtractor for the execute-stage ALU. It accepts one operation per start pulse and processes one 4-bit nibble per clock, LSB first, using a single 4-bit add/sub slice. It returns a registered result with overflow, zero and negative flags, and optionally saturates (PADDSB-style clamping at word level). The flag outputs feed the processor flag register. The `done` pulse is the stall-release handshake for the pipeline.

---
 rtl/addsub_serial16_pkg.sv | 11 +
 rtl/addsub_serial16_slice.sv | 18 +
 rtl/addsub_serial16.sv | 115 +++++++++++
 tb/tb_addsub_serial16.sv | 113 +++++++++++
 4 files changed

// File: rtl/addsub_serial16_pkg.sv
// addsub_serial16_pkg: shared ALU state encoding, slice width and saturation limits
package addsub_serial16_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int NIBBLE_W = 4;
  function automatic logic [63:0] sat_max(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction
  function automatic logic [63:0] sat_min(input int w);
    return 64'd1 << (w - 1);
  endfunction
endpackage

// File: rtl/addsub_serial16_slice.sv
// nibble_addsub_slice: 4-bit add slice on a pre-inverted b with carry chain and msb taps
module nibble_addsub_slice
  import addsub_serial16_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] s,
  output logic                cout,
  output logic                a_msb,
  output logic                b_msb,
  output logic                s_msb
);
  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, cin};
  assign a_msb = a[NIBBLE_W-1];
  assign b_msb = b[NIBBLE_W-1];
  assign s_msb = s[NIBBLE_W-1];
endmodule

// File: rtl/addsub_serial16.sv
// addsub_serial16: nibble-serial signed add/sub with overflow, saturation and flags
module addsub_serial16
  import addsub_serial16_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             sub,
  input  logic             sat,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Ovfl,
  output logic             Zero,
  output logic             Neg
);
  localparam int NSTEP = WIDTH / NIBBLE_W;
  localparam int SW = NSTEP > 1 ? $clog2(NSTEP) : 1;
  localparam logic [WIDTH-1:0] SMAX = WIDTH'(sat_max(WIDTH));
  localparam logic [WIDTH-1:0] SMIN = WIDTH'(sat_min(WIDTH));
  localparam logic [SW-1:0] LAST = SW'(NSTEP - 1);
  state_t state_q, state_d;
  logic [SW-1:0] step_q, step_d;
  logic [WIDTH-1:0] a_q, a_d, bx_q, bx_d, acc_q, acc_d, sum_q, sum_d, fin;
  logic carry_q, carry_d, sat_q, sat_d, ovfl_q, ovfl_d, zero_q, zero_d, neg_q, neg_d;
  logic [NIBBLE_W-1:0] s;
  logic cout, a_msb, b_msb, s_msb, ov;
  nibble_addsub_slice u_slice (
    .a    (a_q[NIBBLE_W*step_q +: NIBBLE_W]),
    .b    (bx_q[NIBBLE_W*step_q +: NIBBLE_W]),
    .cin  (carry_q),
    .s    (s),
    .cout (cout),
    .a_msb(a_msb),
    .b_msb(b_msb),
    .s_msb(s_msb)
  );
  assign ov = (a_msb == b_msb) & (a_msb ^ s_msb);
  assign busy = state_q == RUN;
  assign done = state_q == DONE;
  assign Sum = sum_q;
  assign Ovfl = ovfl_q;
  assign Zero = zero_q;
  assign Neg = neg_q;
  // next state: launch from IDLE/DONE, one nibble per RUN cycle, results loaded on the last step
  always_comb begin
    state_d = state_q;
    step_d = step_q;
    a_d = a_q;
    bx_d = bx_q;
    acc_d = acc_q;
    carry_d = carry_q;
    sat_d = sat_q;
    sum_d = sum_q;
    ovfl_d = ovfl_q;
    zero_d = zero_q;
    neg_d = neg_q;
    acc_d[NIBBLE_W*step_q +: NIBBLE_W] = s;
    fin = sat_q & ov ? (a_q[WIDTH-1] ? SMIN : SMAX) : acc_d;
    if (state_q == RUN) begin
      carry_d = cout;
      step_d = step_q + 1'b1;
      if (step_q == LAST) begin
        state_d = DONE;
        step_d = '0;
        sum_d = fin;
        ovfl_d = ov;
        zero_d = fin == '0;
        neg_d = fin[WIDTH-1];
      end
    end else begin
      acc_d = acc_q;
      state_d = start ? RUN : IDLE;
      if (start) begin
        a_d = A;
        bx_d = sub ? ~B : B;
        sat_d = sat;
        carry_d = sub;
        step_d = '0;
      end
    end
  end
  // state and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      step_q <= '0;
      a_q <= '0;
      bx_q <= '0;
      acc_q <= '0;
      carry_q <= 1'b0;
      sat_q <= 1'b0;
      sum_q <= '0;
      ovfl_q <= 1'b0;
      zero_q <= 1'b0;
      neg_q <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q <= step_d;
      a_q <= a_d;
      bx_q <= bx_d;
      acc_q <= acc_d;
      carry_q <= carry_d;
      sat_q <= sat_d;
      sum_q <= sum_d;
      ovfl_q <= ovfl_d;
      zero_q <= zero_d;
      neg_q <= neg_d;
    end
  end
endmodule

// File: tb/tb_addsub_serial16.sv
// tb_addsub_serial16: directed self-checking bench for the nibble-serial add/sub
module tb_addsub_serial16;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, sub = 1'b0, sat = 1'b0;
  logic [15:0] A = '0, B = '0;
  logic busy, done, Ovfl, Zero, Neg;
  logic [15:0] Sum;
  int checks = 0, errors = 0;
  addsub_serial16 dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .sub(sub), .sat(sat),
    .busy(busy), .done(done), .Sum(Sum), .Ovfl(Ovfl), .Zero(Zero), .Neg(Neg)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic launch(input logic [15:0] a, input logic [15:0] b, input logic s, input logic st);
    @(negedge clk);
    A = a; B = b; sub = s; sat = st; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 10) begin
      @(negedge clk);
      n++;
    end
  endtask
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic s, input logic st, input logic [15:0] es,
                        input logic eo, input logic ez, input logic en);
    int n;
    launch(a, b, s, st);
    wait_done(n);
    check({tag, "_lat"}, n, 4);
    check({tag, "_sum"}, Sum, es);
    check({tag, "_ovfl"}, Ovfl, eo);
    check({tag, "_zero"}, Zero, ez);
    check({tag, "_neg"}, Neg, en);
  endtask
  initial begin
    int n, dcnt;
    repeat (2) @(negedge clk);
    check("rst_sum", Sum, 0);
    check("rst_flags", {Ovfl, Zero, Neg}, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b0;
    run_op("add", 16'h1234, 16'h0FFF, 0, 0, 16'h2233, 0, 0, 0);
    run_op("povf", 16'h7FFF, 16'h0001, 0, 0, 16'h8000, 1, 0, 1);
    run_op("psat", 16'h7FFF, 16'h0001, 0, 1, 16'h7FFF, 1, 0, 0);
    run_op("nsat", 16'h8000, 16'h0001, 1, 1, 16'h8000, 1, 0, 1);
    run_op("zero", 16'h0005, 16'h0005, 1, 0, 16'h0000, 0, 1, 0);
    run_op("mm", 16'h8000, 16'h8000, 1, 0, 16'h0000, 0, 1, 0);
    run_op("zm", 16'h0000, 16'h8000, 1, 0, 16'h8000, 1, 0, 1);
    run_op("neg", 16'h0003, 16'h0005, 1, 0, 16'hFFFE, 0, 0, 1);
    // start and operand changes while busy must not disturb the operation
    launch(16'h1111, 16'h2222, 0, 0);
    check("bz_busy0", busy, 1);
    @(negedge clk);
    check("bz_busy1", busy, 1);
    A = 16'h7FFF; B = 16'h7FFF; sub = 1'b1; sat = 1'b1; start = 1'b1;
    @(negedge clk);
    check("bz_busy2", busy, 1);
    start = 1'b0;
    @(negedge clk);
    check("bz_busy3", busy, 1);
    @(negedge clk);
    check("bz_busy4", busy, 0);
    check("bz_done", done, 1);
    check("bz_sum", Sum, 16'h3333);
    check("bz_ovfl", Ovfl, 0);
    dcnt = 0;
    repeat (8) begin
      @(negedge clk);
      dcnt += int'(done);
    end
    check("bz_extra_done", dcnt, 0);
    // back-to-back restart from DONE
    run_op("b2b1", 16'h0100, 16'h0020, 0, 0, 16'h0120, 0, 0, 0);
    A = 16'h0003; B = 16'h0005; sub = 1'b1; sat = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("b2b_busy", busy, 1);
    wait_done(n);
    check("b2b_lat", n, 4);
    check("b2b_sum", Sum, 16'hFFFE);
    check("b2b_neg", Neg, 1);
    // reset in the middle of RUN aborts without a result
    launch(16'h1234, 16'h0FFF, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("ra_sum", Sum, 0);
    check("ra_flags", {Ovfl, Zero, Neg}, 0);
    check("ra_busy", busy, 0);
    check("ra_done", done, 0);
    dcnt = 0;
    repeat (8) begin
      @(negedge clk);
      dcnt += int'(done);
    end
    check("ra_no_done", dcnt, 0);
    run_op("after", 16'h0001, 16'h0001, 0, 0, 16'h0002, 0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
